// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam int          DEFAULT_ADDR_W   = 32;
  localparam int          DEFAULT_INSTR_W  = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          PC_STEP          = 4;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one imem fetch at a time,
// hands the instruction to decode and handles PC redirects.
// Optional build macro FETCH_PERF_CNT_EN enables the fetch/kill perf counters;
// without it the counter outputs are tied to zero.
//
// state | meaning
// IDLE  | post-reset, request goes out next cycle
// REQ   | fetch request offered at pc (held stable once raised)
// WAIT  | request accepted, waiting for the response (kill drops it)
// HOLD  | instruction presented to decode until if_ready or redirect
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                INSTR_W  = DEFAULT_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               stall,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               misalign_err,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_kill_cnt
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               kill_q, kill_d;
  logic               req_pending_q, req_pending_d;
  logic               if_valid_q, if_valid_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic               misalign_q, misalign_d;
  logic               req_fire;

  // Stall only gates a fresh request; once raised the request stays up.
  assign imem_req_valid = (state_q == REQ) && (!stall || req_pending_q);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign if_valid     = if_valid_q;
  assign if_pc        = if_pc_q;
  assign if_instr     = if_instr_q;
  assign misalign_err = misalign_q;

  // Next-state and next-output computation; redirect overrides the PC last.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    kill_d        = kill_q;
    req_pending_d = req_pending_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    misalign_d    = redirect_valid && (redirect_pc[1:0] != 2'b00);

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (req_fire) begin
          fetch_pc_d    = pc_q;
          req_pending_d = 1'b0;
          kill_d        = redirect_valid;
          state_d       = WAIT;
        end else begin
          req_pending_d = imem_req_valid;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            if_instr_d = imem_rsp_data;
            if_pc_d    = fetch_pc_q;
            if_valid_d = 1'b1;
            state_d    = HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          state_d    = REQ;
        end else if (if_ready) begin
          if_valid_d = 1'b0;
          pc_d       = pc_q + ADDR_W'(PC_STEP);
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      kill_q        <= 1'b0;
      req_pending_q <= 1'b0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_instr_q    <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      kill_q        <= kill_d;
      req_pending_q <= req_pending_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      misalign_q    <= misalign_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_kill_q, perf_kill_d;
  logic        drop_event;

  // A drop is either a killed response or a held instruction discarded by redirect.
  assign drop_event = ((state_q == WAIT) && imem_rsp_valid && (kill_q || redirect_valid)) ||
                      ((state_q == HOLD) && redirect_valid);

  // Counter increments; both wrap naturally at 2^32.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_kill_d  = perf_kill_q;
    if (if_valid_q && if_ready && !redirect_valid) perf_fetch_d = perf_fetch_q + 32'd1;
    if (drop_event)                                perf_kill_d  = perf_kill_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_kill_q  <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_kill_q  <= perf_kill_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_kill_cnt  = perf_kill_q;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_kill_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer. Inputs change 1 time unit
// after the rising edge, outputs are sampled on the falling edge. The imem
// model accepts when mem_ready is set and returns data two cycles after the
// accepting edge, giving a four-cycle fetch loop.
module tb_fetch_sequencer;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign_err;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;

  logic        mem_ready;
  logic        mem_auto;
  logic        auto_rsp_valid, man_rsp_valid;
  logic [31:0] auto_rsp_data, man_rsp_data;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .misalign_err  (misalign_err),
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_kill_cnt (perf_kill_cnt)
  );

  assign imem_req_ready = mem_ready;
  assign imem_rsp_valid = mem_auto ? auto_rsp_valid : man_rsp_valid;
  assign imem_rsp_data  = mem_auto ? auto_rsp_data  : man_rsp_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // imem model: two-cycle response latency after the accepting edge.
  initial begin : imem_model
    logic        fire_now, d1_v;
    logic [31:0] fire_addr, d1_a;
    d1_v = 1'b0; d1_a = '0;
    auto_rsp_valid = 1'b0; auto_rsp_data = '0;
    forever begin
      @(negedge clk);
      fire_now  = imem_req_valid && imem_req_ready && !reset;
      fire_addr = imem_req_addr;
      @(posedge clk); #1;
      auto_rsp_valid = d1_v;
      auto_rsp_data  = mem_data(d1_a);
      d1_v = fire_now;
      d1_a = fire_addr;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Leaves the bench at the start of the first REQ cycle after reset.
  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; man_rsp_valid = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    checks++;
    if ({imem_req_valid, if_valid, misalign_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {imem_req_valid, if_valid, misalign_err});
    end
    checks++;
    if ({if_pc, if_instr} !== 64'h0) begin
      errors++; $display("FAIL reset_if_data: got pc=%h instr=%h expected 0/0", if_pc, if_instr);
    end
    checks++;
    if ({perf_fetch_cnt, perf_kill_cnt} !== 64'h0) begin
      errors++; $display("FAIL reset_perf: got %h/%h expected 0/0", perf_fetch_cnt, perf_kill_cnt);
    end
    cyc(); reset = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL first_cycle_idle: got valid=%b expected 0", imem_req_valid);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL first_req: got valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_sequential();
    logic        exp_v, exp_if;
    logic [31:0] exp_addr;
    if_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      exp_v    = (k % 4 == 0);
      exp_if   = (k % 4 == 3);
      exp_addr = 32'(4 * (k / 4));
      checks++;
      if (imem_req_valid !== exp_v) begin
        errors++; $display("FAIL seq_req_valid k=%0d: got %b expected %b", k, imem_req_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (imem_req_addr !== exp_addr) begin
          errors++; $display("FAIL seq_req_addr k=%0d: got %h expected %h", k, imem_req_addr, exp_addr);
        end
      end
      checks++;
      if (if_valid !== exp_if) begin
        errors++; $display("FAIL seq_if_valid k=%0d: got %b expected %b", k, if_valid, exp_if);
      end
      if (exp_if) begin
        checks++;
        if ({if_pc, if_instr} !== {exp_addr, mem_data(exp_addr)}) begin
          errors++; $display("FAIL seq_if_data k=%0d: got %h/%h expected %h/%h", k, if_pc, if_instr, exp_addr, mem_data(exp_addr));
        end
      end
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hC}) begin
      errors++; $display("FAIL seq_fourth_req: got %b/%h expected 1/0000000c", imem_req_valid, imem_req_addr);
    end
    checks++;
    if (perf_fetch_cnt !== (PERF_EN ? 32'd3 : 32'd0)) begin
      errors++; $display("FAIL seq_perf_fetch: got %0d expected %0d", perf_fetch_cnt, PERF_EN ? 3 : 0);
    end
  endtask

  task automatic test_redirect_wait();
    if_ready = 1'b1; mem_ready = 1'b1;
    do_reset();
    mem_auto = 1'b0;
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req_valid, if_valid} !== 2'b00) begin
      errors++; $display("FAIL rw_wait_quiet: got req=%b if=%b expected 0/0", imem_req_valid, if_valid);
    end
    cyc();
    man_rsp_valid = 1'b1; man_rsp_data = 32'hDEAD_BEEF;
    cyc();
    man_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0) begin
      errors++; $display("FAIL rw_killed_rsp: got if_valid=%b expected 0", if_valid);
    end
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL rw_new_req: got %b/%h expected 1/00000100", imem_req_valid, imem_req_addr);
    end
    checks++;
    if (perf_kill_cnt !== (PERF_EN ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL rw_perf_kill: got %0d expected %0d", perf_kill_cnt, PERF_EN ? 1 : 0);
    end
    cyc(); cyc();
    man_rsp_valid = 1'b1; man_rsp_data = 32'h0000_1234;
    cyc();
    man_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h100, 32'h0000_1234}) begin
      errors++; $display("FAIL rw_new_instr: got %b/%h/%h expected 1/00000100/00001234", if_valid, if_pc, if_instr);
    end
    mem_auto = 1'b1;
  endtask

  task automatic test_hold_redirect();
    if_ready = 1'b0; mem_ready = 1'b1;
    do_reset();
    repeat (3) cyc();
    for (int k = 3; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({if_valid, if_pc, if_instr, imem_req_valid} !== {1'b1, 32'h0, mem_data(32'h0), 1'b0}) begin
        errors++; $display("FAIL hold_stable k=%0d: got %b/%h/%h req=%b expected 1/00000000/%h req=0", k, if_valid, if_pc, if_instr, imem_req_valid, mem_data(32'h0));
      end
      cyc();
    end
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0) begin
      errors++; $display("FAIL hold_drop: got if_valid=%b expected 0", if_valid);
    end
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h40}) begin
      errors++; $display("FAIL hold_redirect_addr: got %b/%h expected 1/00000040", imem_req_valid, imem_req_addr);
    end
    checks++;
    if ({perf_fetch_cnt, perf_kill_cnt} !== {32'd0, (PERF_EN ? 32'd1 : 32'd0)}) begin
      errors++; $display("FAIL hold_perf: got %0d/%0d expected 0/%0d", perf_fetch_cnt, perf_kill_cnt, PERF_EN ? 1 : 0);
    end
    repeat (3) cyc();
    @(negedge clk);
    checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'h40}) begin
      errors++; $display("FAIL hold_next_instr: got %b/%h expected 1/00000040", if_valid, if_pc);
    end
  endtask

  task automatic test_stall();
    if_ready = 1'b1; mem_ready = 1'b1; stall = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL stall_blocks k=%0d: got valid=%b expected 0", k, imem_req_valid);
      end
    end
    cyc();
    stall = 1'b0; mem_ready = 1'b0;
    for (int k = 3; k < 8; k++) begin
      if (k > 3) cyc();
      if (k == 4) stall = 1'b1;
      if (k == 7) mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
        errors++; $display("FAIL stall_held k=%0d: got %b/%h expected 1/00000000", k, imem_req_valid, imem_req_addr);
      end
    end
    cyc();
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL stall_after_fire: got valid=%b expected 0", imem_req_valid);
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect_req_fire();
    if_ready = 1'b1; mem_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL rf_old_req: got %b/%h expected 1/00000000", imem_req_valid, imem_req_addr);
    end
    cyc();
    redirect_valid = 1'b0;
    cyc();
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0) begin
      errors++; $display("FAIL rf_rsp_killed: got if_valid=%b expected 0", if_valid);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({if_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h200}) begin
      errors++; $display("FAIL rf_new_req: got if=%b req=%b addr=%h expected 0/1/00000200", if_valid, imem_req_valid, imem_req_addr);
    end
    checks++;
    if (perf_kill_cnt !== (PERF_EN ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL rf_perf_kill: got %0d expected %0d", perf_kill_cnt, PERF_EN ? 1 : 0);
    end
    repeat (3) cyc();
    @(negedge clk);
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h200, mem_data(32'h200)}) begin
      errors++; $display("FAIL rf_instr: got %b/%h/%h expected 1/00000200/%h", if_valid, if_pc, if_instr, mem_data(32'h200));
    end
  endtask

  task automatic test_misalign();
    if_ready = 1'b1; mem_ready = 1'b0;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    checks++;
    if ({misalign_err, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL mis_before: got err=%b req=%b addr=%h expected 0/1/00000000", misalign_err, imem_req_valid, imem_req_addr);
    end
    cyc();
    redirect_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({misalign_err, imem_req_valid, imem_req_addr} !== {1'b1, 1'b1, 32'h100}) begin
      errors++; $display("FAIL mis_pulse: got err=%b req=%b addr=%h expected 1/1/00000100", misalign_err, imem_req_valid, imem_req_addr);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++; $display("FAIL mis_one_cycle: got err=%b expected 0", misalign_err);
    end
    repeat (2) cyc();
    @(negedge clk);
    checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL mis_instr: got %b/%h expected 1/00000100", if_valid, if_pc);
    end
  endtask

  task automatic test_wrap();
    if_ready = 1'b1; mem_ready = 1'b0;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({misalign_err, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL wrap_req: got err=%b req=%b addr=%h expected 0/1/fffffffc", misalign_err, imem_req_valid, imem_req_addr);
    end
    repeat (3) cyc();
    @(negedge clk);
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'hFFFF_FFFC, mem_data(32'hFFFF_FFFC)}) begin
      errors++; $display("FAIL wrap_instr: got %b/%h/%h expected 1/fffffffc/%h", if_valid, if_pc, if_instr, mem_data(32'hFFFF_FFFC));
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL wrap_next: got %b/%h expected 1/00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_reset_mid();
    if_ready = 1'b1; mem_ready = 1'b1;
    do_reset();
    mem_auto = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    cyc();
    redirect_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0; mem_ready = 1'b0;
    man_rsp_valid = 1'b1; man_rsp_data = 32'hBAD0_BAD0;
    @(negedge clk);
    checks++;
    if ({imem_req_valid, if_valid, if_pc, if_instr} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      errors++; $display("FAIL rm_reset_vals: got req=%b if=%b pc=%h instr=%h expected 0/0/0/0", imem_req_valid, if_valid, if_pc, if_instr);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL rm_first_req: got req=%b addr=%h if=%b expected 1/00000000/0", imem_req_valid, imem_req_addr, if_valid);
    end
    cyc();
    man_rsp_valid = 1'b0; mem_ready = 1'b1;
    cyc();
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0) begin
      errors++; $display("FAIL rm_stray_ignored: got if_valid=%b expected 0", if_valid);
    end
    cyc();
    man_rsp_valid = 1'b1; man_rsp_data = 32'h0000_1111;
    cyc();
    man_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h0000_1111}) begin
      errors++; $display("FAIL rm_recover: got %b/%h/%h expected 1/00000000/00001111", if_valid, if_pc, if_instr);
    end
    mem_auto = 1'b1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    if_ready = 1'b0; mem_ready = 1'b1; mem_auto = 1'b1;
    man_rsp_valid = 1'b0; man_rsp_data = '0;
    test_reset();
    test_sequential();
    test_redirect_wait();
    test_hold_redirect();
    test_stall();
    test_redirect_req_fire();
    test_misalign();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
